// File: rtl/dcache_wbuf_bridge_pkg.sv
// Shared types for the Dcache write-buffer / line-refill bridge: size codes,
// read-FSM states and the buffered store entry layout.
package dcache_wbuf_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_DATA,
        R_RESP
    } rd_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } wbuf_entry_t;

    localparam int unsigned WBUF_ENTRY_W = $bits(wbuf_entry_t);

    function automatic logic [31:0] line_align(input logic [31:0] a, input int unsigned ow);
        return a & ~((32'd1 << (ow + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_wbuf_bridge_if.sv
// Dcache-side memory bus and L2-side bus bundles for dcache_wbuf_bridge.
interface dcache_mem_if #(
    parameter int unsigned offset_width = 2
);
    logic                           dcache_mem_req;
    logic                           dcache_mem_wr;
    logic [1:0]                     dcache_mem_size;
    logic [3:0]                     dcache_mem_wstrb;
    logic [31:0]                    dcache_mem_addr;
    logic [31:0]                    dcache_mem_wdata;
    logic                           mem_dcache_addrOK;
    logic                           mem_dcache_dataOK;
    logic [(32<<offset_width)-1:0]  mem_dcache_rdata;
    logic                           mem_dcache_bvalid;

    modport master (
        output dcache_mem_req, dcache_mem_wr, dcache_mem_size, dcache_mem_wstrb,
               dcache_mem_addr, dcache_mem_wdata,
        input  mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata, mem_dcache_bvalid
    );

    modport slave (
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_size, dcache_mem_wstrb,
               dcache_mem_addr, dcache_mem_wdata,
        output mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata, mem_dcache_bvalid
    );
endinterface

interface l2_bus_if;
    logic        l2_req;
    logic        l2_wr;
    logic [31:0] l2_addr;
    logic [1:0]  l2_size;
    logic [3:0]  l2_wstrb;
    logic [31:0] l2_wdata;
    logic        l2_ready;
    logic        l2_rvalid;
    logic [31:0] l2_rdata;
    logic        l2_rlast;

    modport master (
        output l2_req, l2_wr, l2_addr, l2_size, l2_wstrb, l2_wdata,
        input  l2_ready, l2_rvalid, l2_rdata, l2_rlast
    );

    modport slave (
        input  l2_req, l2_wr, l2_addr, l2_size, l2_wstrb, l2_wdata,
        output l2_ready, l2_rvalid, l2_rdata, l2_rlast
    );
endinterface

// File: rtl/dcache_wbuf_bridge_wbuf_fifo.sv
// Synchronous FIFO holding write-through stores; same-cycle push and pop allowed.
module wbuf_fifo #(
    parameter int unsigned WIDTH = 70,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        dout  = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dcache_wbuf_bridge.sv
// Memory-side stage below the Dcache FSM: buffers write-through stores and drains
// them to L2 in order; serves line refills as word bursts once the buffer is empty.
module dcache_wbuf_bridge
    import dcache_wbuf_bridge_pkg::*;
#(
    parameter int unsigned offset_width = 2,
    parameter int unsigned WBUF_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    dcache_mem_if.slave dc,
    l2_bus_if.master    l2
);
    localparam int unsigned WORDS = 1 << offset_width;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;

    rd_state_e               state_q, state_d;
    logic [offset_width-1:0] beat_q, beat_d;
    logic [WORDS-1:0][31:0]  line_q, line_d;
    logic [31:0]             line_addr_q, line_addr_d;
    logic                    bvalid_q, bvalid_d;

    wbuf_entry_t             push_entry, head_entry;
    logic [CNT_W-1:0]        wbuf_count;
    logic                    wbuf_full, wbuf_empty;
    logic                    push, pop, rd_idle, rd_accept, drain;

    assign push_entry = '{addr:  dc.dcache_mem_addr,
                          wdata: dc.dcache_mem_wdata,
                          wstrb: dc.dcache_mem_wstrb,
                          size:  dc.dcache_mem_size};

    wbuf_fifo #(
        .WIDTH (WBUF_ENTRY_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .count (wbuf_count),
        .full  (wbuf_full),
        .empty (wbuf_empty)
    );

    // Full refuses a write even when the head pops this cycle; reads wait for a drained buffer.
    always_comb begin
        rd_idle   = (state_q == R_IDLE);
        push      = rstn & rd_idle & dc.dcache_mem_req & dc.dcache_mem_wr & ~wbuf_full;
        rd_accept = rstn & rd_idle & dc.dcache_mem_req & ~dc.dcache_mem_wr
                    & (wbuf_count == '0) & ~push;
        drain     = rd_idle & ~wbuf_empty;
        pop       = drain & l2.l2_ready;
    end

    always_comb begin
        l2.l2_req   = 1'b0;
        l2.l2_wr    = 1'b0;
        l2.l2_addr  = '0;
        l2.l2_size  = '0;
        l2.l2_wstrb = '0;
        l2.l2_wdata = '0;
        if (drain) begin
            l2.l2_req   = 1'b1;
            l2.l2_wr    = 1'b1;
            l2.l2_addr  = head_entry.addr;
            l2.l2_size  = head_entry.size;
            l2.l2_wstrb = head_entry.wstrb;
            l2.l2_wdata = head_entry.wdata;
        end else if (state_q == R_REQ) begin
            l2.l2_req  = 1'b1;
            l2.l2_addr = line_addr_q;
            l2.l2_size = SIZE_W;
        end
    end

    assign dc.mem_dcache_addrOK = push | rd_accept;
    assign dc.mem_dcache_dataOK = (state_q == R_RESP);
    assign dc.mem_dcache_rdata  = line_q;
    assign dc.mem_dcache_bvalid = bvalid_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        line_addr_d = line_addr_q;
        bvalid_d    = pop;
        unique case (state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    line_addr_d = line_align(dc.dcache_mem_addr, offset_width);
                    state_d     = R_REQ;
                end
            end
            R_REQ: begin
                if (l2.l2_ready) state_d = R_DATA;
            end
            R_DATA: begin
                if (l2.l2_rvalid) begin
                    line_d[beat_q] = l2.l2_rdata;
                    beat_d         = beat_q + offset_width'(1);
                    // Clearing on rlast keeps the next burst aligned even after a short one.
                    if (l2.l2_rlast) begin
                        beat_d  = '0;
                        state_d = R_RESP;
                    end
                end
            end
            R_RESP: state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= R_IDLE;
            beat_q      <= '0;
            line_q      <= '0;
            line_addr_q <= '0;
            bvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            line_addr_q <= line_addr_d;
            bvalid_q    <= bvalid_d;
        end
    end

    rlast_on_final_beat: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == R_DATA && l2.l2_rvalid && l2.l2_rlast) |-> (beat_q == '1))
        else $error("early l2_rlast at beat %0d", beat_q);

endmodule

// File: tb/tb_dcache_wbuf_bridge.sv
// Directed + randomized bench for dcache_wbuf_bridge with an in-bench store/line model.
module tb_dcache_wbuf_bridge;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dcache_mem_if #(.offset_width(2)) dc_if();
    l2_bus_if l2_if();

    dcache_wbuf_bridge #(.offset_width(2), .WBUF_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .dc   (dc_if),
        .l2   (l2_if)
    );

    int errors = 0;
    int checks = 0;
    int bv_cnt = 0;
    int dok_cnt = 0;
    int exp_bv = 0;
    logic [69:0] exp_wr [$];
    logic [69:0] obs_wr [$];

    always @(negedge clk) begin
        if (l2_if.l2_req && l2_if.l2_ready && l2_if.l2_wr)
            obs_wr.push_back({l2_if.l2_addr, l2_if.l2_wdata, l2_if.l2_wstrb, l2_if.l2_size});
        if (dc_if.mem_dcache_bvalid) bv_cnt++;
        if (dc_if.mem_dcache_dataOK) dok_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({dc_if.mem_dcache_addrOK, dc_if.mem_dcache_dataOK,
              dc_if.mem_dcache_bvalid, l2_if.l2_req, l2_if.l2_wr}), '0);
        check({tag, "_l2bus"}, 128'({l2_if.l2_addr, l2_if.l2_size, l2_if.l2_wstrb,
              l2_if.l2_wdata}), '0);
        check({tag, "_rdata"}, dc_if.mem_dcache_rdata, '0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] sz, output int unsigned waited);
        dc_if.dcache_mem_req   = 1'b1;
        dc_if.dcache_mem_wr    = 1'b1;
        dc_if.dcache_mem_addr  = a;
        dc_if.dcache_mem_wdata = d;
        dc_if.dcache_mem_wstrb = s;
        dc_if.dcache_mem_size  = sz;
        waited = 0;
        @(negedge clk);
        while (!dc_if.mem_dcache_addrOK && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("store_accept", 128'(dc_if.mem_dcache_addrOK), 128'(1));
        if (dc_if.mem_dcache_addrOK) begin
            exp_wr.push_back({a, d, s, sz});
            exp_bv++;
        end
        @(posedge clk); #1;
        dc_if.dcache_mem_req = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int unsigned n = 0;
        while (bv_cnt != exp_bv && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_bvalid_total"}, 128'(bv_cnt), 128'(exp_bv));
        check({tag, "_l2_store_count"}, 128'(obs_wr.size()), 128'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check($sformatf("%s_l2_store%0d", tag, i), 128'(obs_wr[i]), 128'(exp_wr[i]));
        obs_wr.delete();
        exp_wr.delete();
        @(posedge clk); #1;
    endtask

    task automatic line_read(input logic [31:0] a, input int unsigned gaps [4],
                             output int unsigned waited);
        logic [127:0] want;
        int dok0;
        want = '0;
        l2_if.l2_ready = 1'b1;
        dc_if.dcache_mem_req   = 1'b1;
        dc_if.dcache_mem_wr    = 1'b0;
        dc_if.dcache_mem_addr  = a;
        dc_if.dcache_mem_wdata = $urandom;
        waited = 0;
        @(negedge clk);
        while (!dc_if.mem_dcache_addrOK && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        check("rd_accept", 128'(dc_if.mem_dcache_addrOK), 128'(1));
        check("rd_after_drain", 128'(obs_wr.size()), 128'(exp_wr.size()));
        @(posedge clk); #1;
        dc_if.dcache_mem_req = 1'b0;
        @(negedge clk);
        check("rd_l2_req", 128'({l2_if.l2_req, l2_if.l2_wr, l2_if.l2_size, l2_if.l2_addr}),
              128'({1'b1, 1'b0, 2'd2, a & 32'hFFFF_FFF0}));
        @(posedge clk); #1;
        dok0 = dok_cnt;
        for (int i = 0; i < 4; i++) begin
            for (int unsigned g = 0; g < gaps[i]; g++) begin
                l2_if.l2_rvalid = 1'b0;
                l2_if.l2_rdata  = $urandom;
                l2_if.l2_rlast  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            l2_if.l2_rvalid = 1'b1;
            l2_if.l2_rdata  = $urandom;
            l2_if.l2_rlast  = (i == 3);
            want[i*32 +: 32] = l2_if.l2_rdata;
            if (i == 3) check("rd_no_early_dataok", 128'(dok_cnt), 128'(dok0));
            @(posedge clk); #1;
            l2_if.l2_rvalid = 1'b0;
            l2_if.l2_rlast  = 1'b0;
        end
        @(negedge clk);
        check("rd_dataok", 128'(dc_if.mem_dcache_dataOK), 128'(1));
        check("rd_line", dc_if.mem_dcache_rdata, want);
        @(negedge clk);
        check("rd_dataok_pulse", 128'(dc_if.mem_dcache_dataOK), 128'(0));
        check("rd_dataok_count", 128'(dok_cnt), 128'(dok0 + 1));
        check("rd_line_hold", dc_if.mem_dcache_rdata, want);
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned w;
        int unsigned g0 [4];
        int unsigned g4 [4];
        int unsigned gr [4];
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic [3:0]  s;
        g0 = '{0, 0, 0, 0};
        g4 = '{2, 2, 0, 2};

        rstn = 1'b1;
        dc_if.dcache_mem_req = 1'b0;   dc_if.dcache_mem_wr = 1'b0;
        dc_if.dcache_mem_size = '0;    dc_if.dcache_mem_wstrb = '0;
        dc_if.dcache_mem_addr = '0;    dc_if.dcache_mem_wdata = '0;
        l2_if.l2_ready = 1'b0;         l2_if.l2_rvalid = 1'b0;
        l2_if.l2_rdata = '0;           l2_if.l2_rlast = 1'b0;
        #1 rstn = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // 1: back-to-back word stores with L2 always ready
        l2_if.l2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(32'h100 + 32'(4 * i), $urandom, 4'hF, 2'd2, w);
            check($sformatf("t1_b2b_accept%0d", i), 128'(w), 128'(0));
        end
        drain_check("t1");

        // 2: L2 stalled; fifth store refused until a pop, and not in the pop cycle itself
        l2_if.l2_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h400 + 32'(4 * i), $urandom, 4'hF, 2'd2, w);
            check($sformatf("t2_accept%0d", i), 128'(w), 128'(0));
        end
        d = $urandom;
        dc_if.dcache_mem_req = 1'b1;       dc_if.dcache_mem_wr = 1'b1;
        dc_if.dcache_mem_addr = 32'h410;   dc_if.dcache_mem_wdata = d;
        dc_if.dcache_mem_wstrb = 4'hF;     dc_if.dcache_mem_size = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("t2_full_refuse", 128'(dc_if.mem_dcache_addrOK), 128'(0));
        end
        @(posedge clk); #1;
        l2_if.l2_ready = 1'b1;
        @(negedge clk);
        check("t2_refuse_in_pop_cycle", 128'(dc_if.mem_dcache_addrOK), 128'(0));
        @(negedge clk);
        check("t2_accept_after_pop", 128'(dc_if.mem_dcache_addrOK), 128'(1));
        exp_wr.push_back({32'h410, d, 4'hF, 2'd2});
        exp_bv++;
        @(posedge clk); #1;
        dc_if.dcache_mem_req = 1'b0;
        drain_check("t2");

        // 3: read behind two buffered stores waits for the drain
        l2_if.l2_ready = 1'b0;
        store(32'h104, $urandom, 4'hF, 2'd2, w);
        store(32'h108, $urandom, 4'hF, 2'd2, w);
        dc_if.dcache_mem_req = 1'b1;  dc_if.dcache_mem_wr = 1'b0;
        dc_if.dcache_mem_addr = 32'h104;
        repeat (2) begin
            @(negedge clk);
            check("t3_read_blocked", 128'(dc_if.mem_dcache_addrOK), 128'(0));
        end
        @(posedge clk); #1;
        line_read(32'h104, g0, w);
        drain_check("t3");

        // 4: beats arrive with gaps
        line_read(32'h48C, g4, w);

        // 5: byte store passes through untouched
        l2_if.l2_ready = 1'b0;
        d = $urandom;
        store(32'h203, d, 4'b0100, 2'd0, w);
        @(negedge clk);
        check("t5_l2_fields", 128'({l2_if.l2_req, l2_if.l2_wr, l2_if.l2_addr, l2_if.l2_size,
              l2_if.l2_wstrb, l2_if.l2_wdata}), 128'({1'b1, 1'b1, 32'h203, 2'd0, 4'b0100, d}));
        @(posedge clk); #1;
        l2_if.l2_ready = 1'b1;
        drain_check("t5");

        // 6a: reset with two stores buffered drops them silently
        l2_if.l2_ready = 1'b0;
        store(32'h600, $urandom, 4'hF, 2'd2, w);
        store(32'h604, $urandom, 4'hF, 2'd2, w);
        rstn = 1'b0;
        #1 check_idle_outputs("t6a_reset");
        exp_bv -= exp_wr.size();
        exp_wr.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        l2_if.l2_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t6a_no_bvalid", 128'(bv_cnt), 128'(exp_bv));
        check("t6a_no_l2_store", 128'(obs_wr.size()), 128'(0));
        @(posedge clk); #1;
        line_read(32'h620, g0, w);
        check("t6a_read_immediate", 128'(w), 128'(0));

        // 6b: reset in the middle of a burst
        dc_if.dcache_mem_req = 1'b1;  dc_if.dcache_mem_wr = 1'b0;
        dc_if.dcache_mem_addr = 32'h700;
        @(negedge clk);
        check("t6b_accept", 128'(dc_if.mem_dcache_addrOK), 128'(1));
        @(posedge clk); #1;
        dc_if.dcache_mem_req = 1'b0;
        @(posedge clk); #1;
        l2_if.l2_rvalid = 1'b1;  l2_if.l2_rdata = 32'hDEAD_0001;
        @(posedge clk); #1;
        l2_if.l2_rdata = 32'hDEAD_0002;
        @(posedge clk); #1;
        l2_if.l2_rvalid = 1'b0;
        rstn = 1'b0;
        #1 check_idle_outputs("t6b_reset");
        @(negedge clk);
        check_idle_outputs("t6b_reset_next");
        rstn = 1'b1;
        @(posedge clk); #1;
        line_read(32'h744, g0, w);
        check("t6b_read_immediate", 128'(w), 128'(0));

        // randomized mix of stores and refills
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                sz = 2'($urandom_range(0, 2));
                a  = $urandom;
                if (sz == 2'd2) begin a[1:0] = 2'b00; s = 4'hF; end
                else if (sz == 2'd1) begin a[0] = 1'b0; s = 4'b0011 << {a[1], 1'b0}; end
                else s = 4'b0001 << a[1:0];
                store(a, $urandom, s, sz, w);
            end else begin
                l2_if.l2_rvalid = 1'b1;  l2_if.l2_rlast = 1'b1;
                l2_if.l2_rdata  = $urandom;
                @(posedge clk); #1;
                l2_if.l2_rvalid = 1'b0;  l2_if.l2_rlast = 1'b0;
                for (int j = 0; j < 4; j++) gr[j] = $urandom_range(0, 2);
                line_read($urandom, gr, w);
            end
        end
        drain_check("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
